// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, flag bundle, FSM states.
package alu_pkg;

   localparam int OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_ADD, OP_SUB, OP_MUL, OP_DIV,
      OP_SHL, OP_SHR, OP_ROL, OP_ROR,
      OP_AND, OP_OR, OP_XOR, OP_NOR,
      OP_NAND, OP_XNOR, OP_GT, OP_EQ
   } op_e;

   typedef struct packed {
      logic v;
      logic n;
      logic c;
      logic z;
   } flags_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
module alu_muldiv_iter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             ovf_o
);

   localparam int CW = $clog2(WIDTH);

   // acc holds {partial product hi, multiplier} or {remainder, dividend/quotient}
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q;
   logic               div_q;
   logic               busy_q;
   logic [CW-1:0]      cnt_q;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     rs;
   logic [WIDTH-1:0]   rem;
   logic               ge;

   always_comb begin
      sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
          + (acc_q[0] ? {1'b0, opnd_q} : '0);
      rs  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      ge  = rs >= {1'b0, opnd_q};
      rem = ge ? rs[WIDTH-1:0] - opnd_q : rs[WIDTH-1:0];
      if (div_q) begin
         acc_d = {rem, acc_q[WIDTH-2:0], ge};
      end else begin
         acc_d = {sum, acc_q[WIDTH-1:1]};
      end
   end

   assign done_o   = busy_q && (cnt_q == CW'(WIDTH-1));
   assign result_o = acc_d[WIDTH-1:0];
   assign ovf_o    = div_q ? (opnd_q == '0)
                           : (|acc_d[2*WIDTH-1:WIDTH]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         opnd_q <= '0;
         div_q  <= 1'b0;
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else if (start_i) begin
         acc_q  <= {{WIDTH{1'b0}}, a_i};
         opnd_q <= b_i;
         div_q  <= div_i;
         busy_q <= 1'b1;
         cnt_q  <= '0;
      end else if (busy_q) begin
         acc_q <= acc_d;
         cnt_q <= cnt_q + 1'b1;
         if (done_o) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with registered result and {V,N,C,Z} flags.
// Define ALU_MULDIV_EN to build the iterative MUL/DIV unit and BUSY state.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int SW = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] result_q;
   flags_t           flags_q;

   logic             accept;
   logic             is_md;
   logic [SW-1:0]    sh;
   logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w;
   logic [WIDTH-1:0] res_c;
   logic             c_c, v_c;
   flags_t           flg_c;

   assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign flags     = flags_q;

`ifdef ALU_MULDIV_EN
   logic             md_done;
   logic [WIDTH-1:0] md_res;
   logic             md_ovf;

   assign is_md = (op == OP_MUL) || (op == OP_DIV);

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk      (clk),
      .rst      (rst),
      .start_i  (accept && is_md),
      .div_i    (op[0]),
      .a_i      (a),
      .b_i      (b),
      .done_o   (md_done),
      .result_o (md_res),
      .ovf_o    (md_ovf)
   );
`else
   assign is_md = 1'b0;
`endif

   always_comb begin
      sh    = b[SW-1:0];
      add_w = {1'b0, a} + {1'b0, b};
      sub_w = {1'b0, a} - {1'b0, b};
      shl_w = {1'b0, a} << sh;
      shr_w = {a, 1'b0} >> sh;
      res_c = '0;
      c_c   = 1'b0;
      v_c   = 1'b0;
      unique case (op_e'(op))
         OP_ADD: begin
            res_c = add_w[WIDTH-1:0];
            c_c   = add_w[WIDTH];
            v_c   = (a[WIDTH-1] == b[WIDTH-1])
                 && (add_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            res_c = sub_w[WIDTH-1:0];
            c_c   = ~sub_w[WIDTH];
            v_c   = (a[WIDTH-1] != b[WIDTH-1])
                 && (sub_w[WIDTH-1] != a[WIDTH-1]);
         end
         // Without the iterative unit these report overflow with a zero result
         OP_MUL, OP_DIV: v_c = 1'b1;
         OP_SHL: begin
            res_c = shl_w[WIDTH-1:0];
            c_c   = shl_w[WIDTH];
         end
         OP_SHR: begin
            res_c = shr_w[WIDTH:1];
            c_c   = shr_w[0];
         end
         OP_ROL:  res_c = WIDTH'(({a, a} << sh) >> WIDTH);
         OP_ROR:  res_c = WIDTH'({a, a} >> sh);
         OP_AND:  res_c = a & b;
         OP_OR:   res_c = a | b;
         OP_XOR:  res_c = a ^ b;
         OP_NOR:  res_c = ~(a | b);
         OP_NAND: res_c = ~(a & b);
         OP_XNOR: res_c = ~(a ^ b);
         OP_GT:   res_c = WIDTH'(a > b);
         OP_EQ:   res_c = WIDTH'(a == b);
      endcase
      flg_c = '{v: v_c, n: res_c[WIDTH-1], c: c_c, z: (res_c == '0)};
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = is_md ? BUSY : DONE;
`ifdef ALU_MULDIV_EN
         BUSY: if (md_done) state_d = DONE;
`endif
         DONE: begin
            if (out_ready) begin
               if (accept) state_d = is_md ? BUSY : DONE;
               else        state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept && !is_md) begin
            result_q <= res_c;
            flags_q  <= flg_c;
         end
`ifdef ALU_MULDIV_EN
         else if (md_done) begin
            result_q <= md_res;
            flags_q  <= '{v: md_ovf, n: md_res[WIDTH-1],
                          c: 1'b0, z: (md_res == '0)};
         end
`endif
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;

   localparam int W = 8;
`ifdef ALU_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [3:0]   op = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic [3:0]   flags;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sx(input int unsigned x);
      return (x >= (1 << (W-1))) ? int'(x) - (1 << W) : int'(x);
   endfunction

   function automatic void model(input int unsigned ma, input int unsigned mb,
                                 input int unsigned mop,
                                 output int unsigned r, output logic [3:0] f);
      int unsigned m;
      int unsigned sh;
      int s;
      int hi;
      int lo;
      logic v;
      logic c;
      m  = (1 << W) - 1;
      sh = mb % W;
      hi = (1 << (W-1)) - 1;
      lo = -(1 << (W-1));
      v  = 1'b0;
      c  = 1'b0;
      r  = 0;
      case (mop)
         0: begin
            r = (ma + mb) & m;
            c = (ma + mb) > m;
            s = sx(ma) + sx(mb);
            v = (s > hi) || (s < lo);
         end
         1: begin
            r = (ma - mb) & m;
            c = ma >= mb;
            s = sx(ma) - sx(mb);
            v = (s > hi) || (s < lo);
         end
         2: begin
            if (MD) begin
               r = (ma * mb) & m;
               v = ((ma * mb) >> W) != 0;
            end else v = 1'b1;
         end
         3: begin
            if (MD) begin
               if (mb == 0) begin r = m; v = 1'b1; end
               else r = ma / mb;
            end else v = 1'b1;
         end
         4: begin
            r = (ma << sh) & m;
            c = (sh != 0) ? ((ma >> (W - sh)) & 1) != 0 : 1'b0;
         end
         5: begin
            r = ma >> sh;
            c = (sh != 0) ? ((ma >> (sh - 1)) & 1) != 0 : 1'b0;
         end
         6: r = ((ma << sh) | (ma >> (W - sh))) & m;
         7: r = ((ma >> sh) | (ma << (W - sh))) & m;
         8: r = ma & mb;
         9: r = ma | mb;
         10: r = ma ^ mb;
         11: r = ~(ma | mb) & m;
         12: r = ~(ma & mb) & m;
         13: r = ~(ma ^ mb) & m;
         14: r = (ma > mb) ? 1 : 0;
         default: r = (ma == mb) ? 1 : 0;
      endcase
      f = {v, ((r >> (W-1)) & 1) != 0, c, r == 0};
   endfunction

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic [3:0] top, input int hold,
                         input string tag);
      int unsigned er;
      logic [3:0]  ef;
      int          lat;
      int          elat;
      model(ta, tb_, top, er, ef);
      elat = (MD && (top == 2 || top == 3)) ? W + 1 : 1;
      @(negedge clk);
      a = ta; b = tb_; op = top;
      in_valid = 1'b1; out_ready = 1'b0;
      #1 check({tag, " ready"}, in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); op = 4'($urandom);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!out_valid) check({tag, " busy"}, in_ready, 0);
      end while (!out_valid && lat < 40);
      check({tag, " latency"}, lat, elat);
      check({tag, " result"}, result, er);
      check({tag, " flags"}, flags, ef);
      repeat (hold) begin
         @(negedge clk);
         check({tag, " hold valid"}, out_valid, 1);
         check({tag, " hold result"}, result, er);
         check({tag, " hold flags"}, flags, ef);
         check({tag, " hold ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      #1 check({tag, " drain ready"}, in_ready, 1);
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check({tag, " drained"}, out_valid, 0);
   endtask

   initial begin
      int unsigned pr;
      logic [3:0]  pf;
      int unsigned er;
      logic [3:0]  ef;

      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst valid", out_valid, 0);
      check("rst result", result, 0);
      check("rst flags", flags, 0);
      rst = 1'b0;
      #1 check("rst ready", in_ready, 1);

      run_op(8'h0A, 8'h02, 4'd0, 0, "add small");
      run_op(8'hF6, 8'h0A, 4'd0, 0, "add wrap");
      for (int i = 0; i < 16; i++) begin
         run_op(8'h0A, 8'h02, 4'(i), 0, $sformatf("sweep op%0d", i));
      end
      run_op(8'h37, 8'h00, 4'd3, 0, "div zero");
      run_op(8'h0A, 8'h02, 4'd0, 5, "hold add");
      run_op(8'h85, 8'h07, 4'd2, 3, "hold mul");

      @(negedge clk);
      a = 8'h0A; b = 8'h03; op = 4'd2; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1 check("midrst valid", out_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("midrst ready", in_ready, 1);
      check("midrst valid2", out_valid, 0);
      repeat (W + 2) @(negedge clk);
      check("midrst no result", out_valid, 0);
      run_op(8'h21, 8'h13, 4'd0, 0, "post rst add");

      pr = 0; pf = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i > 0) begin
            check("b2b valid", out_valid, 1);
            check("b2b result", result, pr);
            check("b2b flags", flags, pf);
         end
         a = W'($urandom); b = W'($urandom);
         op = (i % 2) ? 4'd10 : 4'd0;
         model(a, b, op, pr, pf);
         in_valid = 1'b1; out_ready = 1'b1;
         #1 check("b2b ready", in_ready, 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b last valid", out_valid, 1);
      check("b2b last result", result, pr);
      check("b2b last flags", flags, pf);
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check("b2b idle", out_valid, 0);

      for (int i = 0; i < 60; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = W'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         run_op(ra, rb, 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
      end

      model(8'hFF, 8'h01, 0, er, ef);
      run_op(8'hFF, 8'h01, 4'd0, 0, "add carry");
      run_op(8'h7F, 8'h01, 4'd0, 0, "add ovf");
      run_op(8'h80, 8'h01, 4'd1, 0, "sub ovf");
      run_op(8'h81, 8'h08, 4'd4, 0, "shl zero amt");
      run_op(8'h81, 8'h07, 4'd5, 0, "shr max amt");
      run_op(8'hFF, 8'hFF, 4'd2, 0, "mul max");
      check("model add carry", {28'd0, ef}, 32'h3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
